vote_session_ctrl: RTL



---
 rtl/vote_session_ctrl_pkg.sv | 35 +++
 rtl/vote_session_ctrl_key_debounce.sv | 70 +++++++
 rtl/vote_session_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vote_session_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vote_session_ctrl_pkg
// Description : Shared definitions for the voting session controller:
//               FSM state encoding, voter count, default timing constants
//               and a small popcount helper.
// Revision    : 1.0  initial release
// ============================================================================
package vote_session_ctrl_pkg;

  // Session FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VOTING = 2'd1,
    EVAL   = 2'd2,
    RESULT = 2'd3
  } state_t;

  localparam int          c_num_voters          = 5;
  localparam int          c_win_w               = 24;
  localparam int          c_def_deb_cycles      = 20000;
  localparam int unsigned c_def_window_cycles   = 10_000_000;

  // Number of set bits in a voter vector (0..5)
  function automatic logic [2:0] popcount5(input logic [c_num_voters-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < c_num_voters; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vote_session_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchronizer, consecutive-sample debounce counter
//               and rising-edge detector for one raw push button.
// Revision    : 1.0  initial release
// ============================================================================
module key_debounce
  import vote_session_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = c_def_deb_cycles
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_lvl,
  output logic key_rise
);

  // The counter only needs to reach DEB_CYCLES-1; the level flips on that sample.
  localparam int                  c_cnt_w    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_lvl;
  logic               r_lvl_prev;
  logic [c_cnt_w-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lvl <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync2 == r_lvl) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_lvl <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // Remember the previous debounced level for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lvl_prev <= 1'b0;
    end else begin
      r_lvl_prev <= r_lvl;
    end
  end

  assign key_lvl  = r_lvl;
  assign key_rise = r_lvl & ~r_lvl_prev;

endmodule
`default_nettype wire

// File: rtl/vote_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vote_session_ctrl
// Description : Five-voter session controller. Debounces the voter and start
//               keys, runs a bounded voting window, latches yes-votes for the
//               downstream majority voter and holds the resulting verdict and
//               yes-count for display.
// Revision    : 1.0  initial release
// ============================================================================
module vote_session_ctrl
  import vote_session_ctrl_pkg::*;
#(
  parameter int          DEB_CYCLES    = c_def_deb_cycles,
  parameter int unsigned WINDOW_CYCLES = c_def_window_cycles
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_key,
  input  logic [4:0] key_in,
  input  logic       maj_y,
  output logic [4:0] vote,
  output logic       busy,
  output logic       result_valid,
  output logic       pass,
  output logic [2:0] vote_cnt
);

  // Window counter starts at WINDOW_CYCLES-1 so VOTING lasts at most WINDOW_CYCLES clocks
  localparam logic [c_win_w-1:0] c_win_load = c_win_w'(WINDOW_CYCLES - 1);
  localparam logic [c_win_w-1:0] c_win_one  = c_win_w'(1);
  localparam logic [4:0]         c_all_yes  = 5'b11111;

  state_t             r_state;
  state_t             state_nxt;
  logic [4:0]         r_vote;
  logic [4:0]         vote_nxt;
  logic [c_win_w-1:0] r_win;
  logic [c_win_w-1:0] win_nxt;
  logic               r_pass;
  logic               pass_nxt;
  logic [2:0]         r_vote_cnt;

  logic [4:0]         key_lvl;
  logic [4:0]         key_rise;
  logic               start_lvl;
  logic               start_rise;
  logic [4:0]         w_vote_acc;
  logic               w_unused;

  // One conditioner per voter key
  for (genvar i = 0; i < c_num_voters; i++) begin : g_voter_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_raw  (key_in[i]),
      .key_lvl  (key_lvl[i]),
      .key_rise (key_rise[i])
    );
  end

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_start_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_raw  (start_key),
    .key_lvl  (start_lvl),
    .key_rise (start_rise)
  );

  // Only the edges drive the session; the levels are not needed here
  assign w_unused = ^{key_lvl, start_lvl};

  // Votes including any rise on this cycle, so a last-cycle press still counts
  assign w_vote_acc = r_vote | key_rise;

  // Session state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= state_nxt;
    end
  end

  // Next-state, datapath next values and status outputs
  always_comb begin
    state_nxt    = r_state;
    vote_nxt     = r_vote;
    win_nxt      = r_win;
    pass_nxt     = r_pass;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_rise) begin
          state_nxt = VOTING;
          vote_nxt  = '0;
          win_nxt   = c_win_load;
          pass_nxt  = 1'b0;
        end
      end
      VOTING: begin
        busy     = 1'b1;
        vote_nxt = w_vote_acc;
        if (r_win != '0) begin
          win_nxt = r_win - c_win_one;
        end
        if ((r_win == '0) || (w_vote_acc == c_all_yes)) begin
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        // vote has been stable since the last VOTING edge, so maj_y is settled
        pass_nxt  = maj_y;
        state_nxt = RESULT;
      end
      RESULT: begin
        result_valid = 1'b1;
        // A new session clears the votes; a key rise on this same edge is dropped
        if (start_rise) begin
          state_nxt = VOTING;
          vote_nxt  = '0;
          win_nxt   = c_win_load;
          pass_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Vote, window and verdict registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vote <= '0;
      r_win  <= '0;
      r_pass <= 1'b0;
    end else begin
      r_vote <= vote_nxt;
      r_win  <= win_nxt;
      r_pass <= pass_nxt;
    end
  end

  // Yes-count for the display, one clock behind vote
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vote_cnt <= '0;
    end else begin
      r_vote_cnt <= popcount5(r_vote);
    end
  end

  assign vote     = r_vote;
  assign pass     = r_pass;
  assign vote_cnt = r_vote_cnt;

endmodule
`default_nettype wire
